// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter of the dual-issue cpu.
// Word-address/data widths, arbiter FSM state type and the per-pipe request bundle.
package dm_arbiter_pkg;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    typedef enum logic [0:0] {
        StIdle,
        StP1Turn
    } dm_arb_state_t;

    typedef struct packed {
        logic          req;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dm_req_t;

    // Both pipes present a request to the same word this cycle.
    function automatic logic same_word(input dm_req_t a, input dm_req_t b);
        return a.req && b.req && (a.addr == b.addr);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the two MEM-stage DM ports, the pipeline stall and the DM macro port.
// slave = arbiter side, master = pipeline + memory side.
interface dm_arbiter_if;
    import dm_arbiter_pkg::*;

    logic          p0_req;
    logic          p0_write_mem;
    logic [AW-1:0] p0_maddr;
    logic [DW-1:0] p0_wdata;
    logic [DW-1:0] p0_rdata;
    logic          p0_rvalid;

    logic          p1_req;
    logic          p1_write_mem;
    logic [AW-1:0] p1_maddr;
    logic [DW-1:0] p1_wdata;
    logic [DW-1:0] p1_rdata;
    logic          p1_rvalid;

    logic          stall;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_en;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_write_mem, p0_maddr, p0_wdata,
        input  p1_req, p1_write_mem, p1_maddr, p1_wdata,
        input  mem_rdata,
        output p0_rdata, p0_rvalid, p1_rdata, p1_rvalid,
        output stall, mem_addr, mem_wdata, mem_write, mem_en
    );

    modport master (
        output p0_req, p0_write_mem, p0_maddr, p0_wdata,
        output p1_req, p1_write_mem, p1_maddr, p1_wdata,
        output mem_rdata,
        input  p0_rdata, p0_rvalid, p1_rdata, p1_rvalid,
        input  stall, mem_addr, mem_wdata, mem_write, mem_en
    );

endinterface

// File: rtl/dm_arbiter_rd_return.sv
// Per-pipe read-return register: pulses rvalid the cycle after a read (or forward) is issued
// and holds the last returned word until that pipe's next read completes.
module dm_arbiter_rd_return
    import dm_arbiter_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rd,
    input  logic          i_fwd,
    input  logic [DW-1:0] i_fwd_data,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_rvalid
);

    logic          r_valid;
    logic          r_fwd;
    logic [DW-1:0] r_fwd_data;
    logic [DW-1:0] r_hold;
    logic [DW-1:0] w_ret_data;

    // The DM output only exists in the return cycle, so it bypasses the hold register then.
    assign w_ret_data = r_fwd ? r_fwd_data : i_mem_rdata;
    assign o_rdata    = r_valid ? w_ret_data : r_hold;
    assign o_rvalid   = r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
            r_hold     <= '0;
        end else begin
            r_valid <= i_rd | i_fwd;
            r_fwd   <= i_fwd;
            if (i_fwd) begin
                r_fwd_data <= i_fwd_data;
            end
            if (r_valid) begin
                r_hold <= w_ret_data;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the p0/p1 MEM-stage ports onto one single-ported synchronous DM.
// Conflicting pairs are serialised p0 then p1 with one stall cycle; same-word pairs are merged.
module dm_arbiter
    import dm_arbiter_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    dm_arbiter_if.slave bus
);

    dm_arb_state_t r_state;
    dm_arb_state_t w_state_d;

    dm_req_t       w_p0;
    dm_req_t       w_p1;

    logic          w_en;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_stall;
    logic          w_p0_rd;
    logic          w_p1_rd;
    logic          w_p1_fwd;

    assign w_p0 = '{req: bus.p0_req, write: bus.p0_write_mem, addr: bus.p0_maddr,
                    wdata: bus.p0_wdata};
    assign w_p1 = '{req: bus.p1_req, write: bus.p1_write_mem, addr: bus.p1_maddr,
                    wdata: bus.p1_wdata};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_en      = 1'b0;
        w_we      = 1'b0;
        w_addr    = w_p0.addr;
        w_wdata   = w_p0.wdata;
        w_stall   = 1'b0;
        w_p0_rd   = 1'b0;
        w_p1_rd   = 1'b0;
        w_p1_fwd  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (same_word(w_p0, w_p1)) begin
                    w_en   = 1'b1;
                    w_addr = w_p0.addr;
                    unique case ({w_p0.write, w_p1.write})
                        2'b00: begin
                            w_p0_rd = 1'b1;
                            w_p1_rd = 1'b1;
                        end
                        2'b01: begin
                            // DM is read-before-write: p0 sees the old word.
                            w_we    = 1'b1;
                            w_wdata = w_p1.wdata;
                            w_p0_rd = 1'b1;
                        end
                        2'b10: begin
                            w_we     = 1'b1;
                            w_wdata  = w_p0.wdata;
                            w_p1_fwd = 1'b1;
                        end
                        default: begin
                            // p1 is younger, so its write is the one that survives.
                            w_we    = 1'b1;
                            w_wdata = w_p1.wdata;
                        end
                    endcase
                end else if (w_p0.req) begin
                    w_en    = 1'b1;
                    w_we    = w_p0.write;
                    w_addr  = w_p0.addr;
                    w_wdata = w_p0.wdata;
                    w_p0_rd = !w_p0.write;
                    if (w_p1.req) begin
                        w_stall   = 1'b1;
                        w_state_d = StP1Turn;
                    end
                end else if (w_p1.req) begin
                    w_en    = 1'b1;
                    w_we    = w_p1.write;
                    w_addr  = w_p1.addr;
                    w_wdata = w_p1.wdata;
                    w_p1_rd = !w_p1.write;
                end
            end
            StP1Turn: begin
                // p0 was served last cycle; its repeated request is ignored.
                w_state_d = StIdle;
                if (w_p1.req) begin
                    w_en    = 1'b1;
                    w_we    = w_p1.write;
                    w_addr  = w_p1.addr;
                    w_wdata = w_p1.wdata;
                    w_p1_rd = !w_p1.write;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // No DM access or stall may escape while reset is asserted.
        if (!i_rst_n) begin
            w_en     = 1'b0;
            w_we     = 1'b0;
            w_stall  = 1'b0;
            w_p0_rd  = 1'b0;
            w_p1_rd  = 1'b0;
            w_p1_fwd = 1'b0;
        end
    end

    assign bus.mem_en    = w_en;
    assign bus.mem_write = w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.stall     = w_stall;

    dm_arbiter_rd_return u_p0_ret (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd        (w_p0_rd),
        .i_fwd       (1'b0),
        .i_fwd_data  (w_p0.wdata),
        .i_mem_rdata (bus.mem_rdata),
        .o_rdata     (bus.p0_rdata),
        .o_rvalid    (bus.p0_rvalid)
    );

    dm_arbiter_rd_return u_p1_ret (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd        (w_p1_rd),
        .i_fwd       (w_p1_fwd),
        .i_fwd_data  (w_p0.wdata),
        .i_mem_rdata (bus.mem_rdata),
        .o_rdata     (bus.p1_rdata),
        .o_rvalid    (bus.p1_rvalid)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a read-before-write synchronous DM model.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    dm_arbiter_if bus();

    dm_arbiter u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dm [512];
    logic [DW-1:0] dm_q = '0;
    logic          dm_init = 1'b0;

    always @(posedge clk) begin
        if (!dm_init) begin
            for (int i = 0; i < 512; i++) dm[i] = '0;
            dm_init <= 1'b1;
        end else if (bus.mem_en) begin
            dm_q <= dm[bus.mem_addr];
            if (bus.mem_write) dm[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = dm_q;

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.p0_req = r0; bus.p0_write_mem = w0; bus.p0_maddr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_write_mem = w1; bus.p1_maddr = a1; bus.p1_wdata = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
        n_vec++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b%b want 00", bus.p0_rvalid, bus.p1_rvalid); end
        @(negedge clk) rst_n = 1'b1;
        // Conflicting pair with a p1 write, then reset lands in the p1 turn.
        @(negedge clk) drive(1'b1, 1'b0, 9'h040, '0, 1'b1, 1'b1, 9'h041, 16'hDEAD);
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst_pair_stall: got %b want 1", bus.stall); end
        @(posedge clk) #1;
        n_vec++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 9'h041) begin n_err++; $display("FAIL rst_p1turn: write=%b addr=%h want 1 041", bus.mem_write, bus.mem_addr); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.mem_en !== 1'b0 || bus.mem_write !== 1'b0 || bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: en=%b we=%b stall=%b want 000", bus.mem_en, bus.mem_write, bus.stall); end
        n_vec++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 16'h0 || bus.p1_rdata !== 16'h0) begin n_err++; $display("FAIL rst_mid_rdata: v=%b d0=%h d1=%h want 0", bus.p0_rvalid, bus.p0_rdata, bus.p1_rdata); end
        @(negedge clk) idle();
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_vec++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rst_release_en: got %b want 0", bus.mem_en); end
        @(posedge clk) #1;
        n_vec++; if (bus.mem_en !== 1'b0 || bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_idle_en: en=%b stall=%b want 00", bus.mem_en, bus.stall); end
        // The abandoned p1 write must not have reached the DM.
        @(negedge clk) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h041, '0);
        @(posedge clk) #1;
        n_vec++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_dropped_write: v=%b d=%h want 1 0000", bus.p1_rvalid, bus.p1_rdata); end
        @(negedge clk) idle();
    endtask

    task automatic test_single();
        @(negedge clk) drive(1'b1, 1'b1, 9'h00A, 16'h1234, 1'b0, 1'b0, '0, '0);
        #1;
        n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_addr !== 9'h00A || bus.mem_wdata !== 16'h1234) begin n_err++; $display("FAIL single_wr: en=%b we=%b a=%h d=%h want 1 1 00a 1234", bus.mem_en, bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL single_wr_stall: got %b want 0", bus.stall); end
        @(negedge clk) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h00A, '0);
        #1;
        n_vec++; if (bus.mem_write !== 1'b0 || bus.mem_addr !== 9'h00A || bus.stall !== 1'b0) begin n_err++; $display("FAIL single_rd: we=%b a=%h stall=%b want 0 00a 0", bus.mem_write, bus.mem_addr, bus.stall); end
        n_vec++; if (bus.p0_rvalid !== 1'b0) begin n_err++; $display("FAIL single_wr_norvalid: got %b want 0", bus.p0_rvalid); end
        @(posedge clk) #1;
        n_vec++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 16'h1234) begin n_err++; $display("FAIL single_rd_data: v=%b d=%h want 1 1234", bus.p1_rvalid, bus.p1_rdata); end
        @(negedge clk) idle();
    endtask

    task automatic test_pair_stall();
        @(negedge clk) drive(1'b1, 1'b1, 9'h010, 16'hAAAA, 1'b0, 1'b0, '0, '0);
        @(negedge clk) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 9'h011, 16'hBBBB);
        @(negedge clk) drive(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h011, '0);
        #1;
        n_vec++; if (bus.stall !== 1'b1 || bus.mem_addr !== 9'h010) begin n_err++; $display("FAIL pair_first: stall=%b a=%h want 1 010", bus.stall, bus.mem_addr); end
        @(posedge clk) #1;
        n_vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 16'hAAAA || bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL pair_p0_data: v0=%b d0=%h v1=%b want 1 aaaa 0", bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid); end
        @(negedge clk) #1;
        n_vec++; if (bus.stall !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 9'h011) begin n_err++; $display("FAIL pair_second: stall=%b en=%b a=%h want 0 1 011", bus.stall, bus.mem_en, bus.mem_addr); end
        @(posedge clk) #1;
        n_vec++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 16'hBBBB) begin n_err++; $display("FAIL pair_p1_data: v=%b d=%h want 1 bbbb", bus.p1_rvalid, bus.p1_rdata); end
        n_vec++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 16'hAAAA) begin n_err++; $display("FAIL pair_p0_hold: v=%b d=%h want 0 aaaa", bus.p0_rvalid, bus.p0_rdata); end
        @(negedge clk) idle();
    endtask

    task automatic test_merge();
        // p0 write / p1 read, same word: forwarded, no stall.
        @(negedge clk) drive(1'b1, 1'b1, 9'h020, 16'h5555, 1'b1, 1'b0, 9'h020, '0);
        #1;
        n_vec++; if (bus.stall !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_wdata !== 16'h5555) begin n_err++; $display("FAIL fwd_access: stall=%b we=%b d=%h want 0 1 5555", bus.stall, bus.mem_write, bus.mem_wdata); end
        @(posedge clk) #1;
        n_vec++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 16'h5555 || bus.p0_rvalid !== 1'b0) begin n_err++; $display("FAIL fwd_data: v1=%b d1=%h v0=%b want 1 5555 0", bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid); end
        // Write/write: only p1's data lands.
        @(negedge clk) drive(1'b1, 1'b1, 9'h030, 16'h1111, 1'b1, 1'b1, 9'h030, 16'h2222);
        #1;
        n_vec++; if (bus.stall !== 1'b0 || bus.mem_wdata !== 16'h2222 || bus.mem_addr !== 9'h030) begin n_err++; $display("FAIL ww_access: stall=%b d=%h a=%h want 0 2222 030", bus.stall, bus.mem_wdata, bus.mem_addr); end
        @(posedge clk) #1;
        n_vec++; if (dm[9'h030] !== 16'h2222) begin n_err++; $display("FAIL ww_dm: got %h want 2222", dm[9'h030]); end
        // p0 read / p1 write: p0 gets the old word.
        @(negedge clk) drive(1'b1, 1'b0, 9'h030, '0, 1'b1, 1'b1, 9'h030, 16'h3333);
        #1;
        n_vec++; if (bus.stall !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_wdata !== 16'h3333) begin n_err++; $display("FAIL rw_access: stall=%b we=%b d=%h want 0 1 3333", bus.stall, bus.mem_write, bus.mem_wdata); end
        @(posedge clk) #1;
        n_vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 16'h2222 || bus.p1_rvalid !== 1'b0) begin n_err++; $display("FAIL rw_data: v0=%b d0=%h v1=%b want 1 2222 0", bus.p0_rvalid, bus.p0_rdata, bus.p1_rvalid); end
        // Read/read of the same word: both pipes get it in one access.
        @(negedge clk) drive(1'b1, 1'b0, 9'h030, '0, 1'b1, 1'b0, 9'h030, '0);
        #1;
        n_vec++; if (bus.stall !== 1'b0 || bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rr_access: stall=%b we=%b want 0 0", bus.stall, bus.mem_write); end
        @(posedge clk) #1;
        n_vec++; if (bus.p0_rdata !== 16'h3333 || bus.p1_rdata !== 16'h3333 || bus.p0_rvalid !== 1'b1 || bus.p1_rvalid !== 1'b1) begin n_err++; $display("FAIL rr_data: d0=%h d1=%h v=%b%b want 3333 3333 11", bus.p0_rdata, bus.p1_rdata, bus.p0_rvalid, bus.p1_rvalid); end
        @(negedge clk) idle();
    endtask

    task automatic test_flush();
        @(negedge clk) drive(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h011, '0);
        #1;
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL flush_stall: got %b want 1", bus.stall); end
        @(negedge clk) drive(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, 9'h011, '0);
        #1;
        n_vec++; if (bus.mem_en !== 1'b0 || bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_noaccess: en=%b stall=%b want 0 0", bus.mem_en, bus.stall); end
        @(posedge clk) #1;
        n_vec++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 16'h3333) begin n_err++; $display("FAIL flush_rvalid: v=%b%b d1=%h want 00 3333", bus.p0_rvalid, bus.p1_rvalid, bus.p1_rdata); end
        @(negedge clk) drive(1'b1, 1'b0, 9'h011, '0, 1'b0, 1'b0, '0, '0);
        #1;
        n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 9'h011 || bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_next: en=%b a=%h stall=%b want 1 011 0", bus.mem_en, bus.mem_addr, bus.stall); end
        @(posedge clk) #1;
        n_vec++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 16'hBBBB) begin n_err++; $display("FAIL flush_next_data: v=%b d=%h want 1 bbbb", bus.p0_rvalid, bus.p0_rdata); end
        @(negedge clk) idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_pair_stall();
        test_merge();
        test_flush();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
